// File: rtl/aespim_reduce_accum_if.sv
// Product-in / residue-out handshake bundle for aespim_reduce_accum.
// Both channels are valid/ready: a transfer happens on a clock edge where valid and ready are both high.
interface aespim_reduce_accum_if #(
    parameter int W       = 32,
    parameter int SHIFT_W = 3
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [2*W-1:0]     in_product_i;
    logic [SHIFT_W-1:0] in_shift_i;
    logic               in_last_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [W-1:0]       out_data_o;

    modport master (
        output in_valid_i, in_product_i, in_shift_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_product_i, in_shift_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/aespim_reduce_accum.sv
// XOR-accumulates shifted carry-less products into a limb buffer, then folds it modulo x^W + POLY_LOW.
// Optional fold statistics on fold_cnt_o are enabled by defining AESPIM_REDUCE_FOLDCNT_EN.
module aespim_reduce_accum #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   POLY_LOW  = 32'h0002_C001,
    parameter int             MAX_SHIFT = 6,
    parameter int             SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    aespim_reduce_accum_if.slave       bus,
    output logic                       err_o,
    output logic [7:0]                 fold_cnt_o,
    output logic [1:0]                 dbg_state
);
    localparam int NLIMB = MAX_SHIFT + 2;
    localparam int TOP_W = $clog2(NLIMB);

    typedef enum logic [1:0] {ACCUM = 2'd0, FOLD = 2'd1, OUT = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       limb [NLIMB];
    logic [TOP_W-1:0]   top;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               err;

    logic               accept, bad_shift, fold_step, dec_step, done_step, out_hs;
    logic [W-1:0]       top_limb;
    logic [2*W-2:0]     fold_t;

    function automatic logic [2*W-2:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ ({{(W-1){1'b0}}, a} << i);
        end
        return r;
    endfunction

    assign top_limb       = limb[top];
    assign fold_t         = clmul(top_limb, POLY_LOW);
    assign bus.in_ready_o  = (state_q == ACCUM);
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign err_o          = err;
    assign dbg_state      = state_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        bad_shift = (int'(bus.in_shift_i) > MAX_SHIFT);
        fold_step = 1'b0;
        dec_step  = 1'b0;
        done_step = 1'b0;
        out_hs    = 1'b0;
        case (state_q)
            ACCUM: begin
                accept = bus.in_valid_i;
                if (accept && bus.in_last_i) state_d = FOLD;
            end
            FOLD: begin
                if (top_limb != '0) begin
                    fold_step = 1'b1;
                end else if (top > TOP_W'(1)) begin
                    dec_step = 1'b1;
                end else begin
                    done_step = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                out_hs = out_valid && bus.out_ready_i;
                if (out_hs) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        // flush overrides everything, including a handshake in the same cycle
        if (flush_i) begin
            state_d   = ACCUM;
            accept    = 1'b0;
            fold_step = 1'b0;
            dec_step  = 1'b0;
            done_step = 1'b0;
            out_hs    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < NLIMB; j++) limb[j] <= '0;
            top       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else if (flush_i) begin
            for (int j = 0; j < NLIMB; j++) limb[j] <= '0;
            top       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= accept && bad_shift;
            for (int j = 0; j < NLIMB; j++) begin
                if (accept && !bad_shift) begin
                    if (j == int'(bus.in_shift_i))
                        limb[j] <= limb[j] ^ bus.in_product_i[W-1:0];
                    else if (j == int'(bus.in_shift_i) + 1)
                        limb[j] <= limb[j] ^ bus.in_product_i[2*W-1:W];
                end
                // fold: the top limb's overflow above x^W is pushed one limb down
                if (fold_step) begin
                    if (j == int'(top))
                        limb[j] <= {1'b0, fold_t[2*W-2:W]};
                    else if (j == int'(top) - 1)
                        limb[j] <= limb[j] ^ fold_t[W-1:0];
                end
                if (out_hs) limb[j] <= '0;
            end
            if (accept && bus.in_last_i) top <= TOP_W'(NLIMB - 1);
            if (dec_step)                top <= top - TOP_W'(1);
            if (done_step) begin
                out_data  <= limb[0];
                out_valid <= 1'b1;
            end
            if (out_hs) out_valid <= 1'b0;
        end
    end

`ifdef AESPIM_REDUCE_FOLDCNT_EN
    logic       in_op;
    logic [7:0] fold_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_op    <= 1'b0;
            fold_cnt <= '0;
        end else if (flush_i) begin
            in_op <= 1'b0;
        end else begin
            if (accept) begin
                in_op <= !bus.in_last_i;
                if (!in_op) fold_cnt <= '0;
            end
            if (fold_step && fold_cnt != 8'hFF) fold_cnt <= fold_cnt + 8'd1;
        end
    end

    assign fold_cnt_o = fold_cnt;
`else
    assign fold_cnt_o = '0;
`endif
endmodule

// File: tb/tb_aespim_reduce_accum.sv
// Directed and randomised checks of aespim_reduce_accum against a bit-serial GF(2)[x] mod-p model.
module tb_aespim_reduce_accum;
    localparam int W = 32;
    localparam int SHIFT_W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       err;
    logic [7:0] fold_cnt;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_err = 0;

    aespim_reduce_accum_if #(.W(W), .SHIFT_W(SHIFT_W)) bus ();

    aespim_reduce_accum dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus),
        .err_o(err), .fold_cnt_o(fold_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mod(input logic [255:0] v);
        logic [255:0] a;
        logic [255:0] pf;
        a  = v;
        pf = 256'h1_0002_C001;
        for (int i = 255; i >= 32; i--) begin
            if (a[i]) a = a ^ (pf << (i - 32));
        end
        return a[31:0];
    endfunction

    task automatic send_beat(input logic [63:0] p, input logic [2:0] s, input logic l);
        int n;
        n = 0;
        bus.in_valid_i   = 1'b1;
        bus.in_product_i = p;
        bus.in_shift_i   = s;
        bus.in_last_i    = l;
        while (!bus.in_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_beat", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp_data,
                             input int exp_lat, input int exp_fold, input int stall);
        int edges;
        logic [31:0] held;
        edges = 0;
        bus.out_ready_i = 1'b0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!bus.out_valid_o && edges < 300);
        chk({tag, "_valid"}, bus.out_valid_o, 1'b1);
        if (exp_lat >= 0) chk({tag, "_latency"}, edges, exp_lat);
        chk({tag, "_data"}, bus.out_data_o, exp_data);
        chk({tag, "_ready_low"}, bus.in_ready_o, 1'b0);
`ifdef AESPIM_REDUCE_FOLDCNT_EN
        if (exp_fold >= 0) chk({tag, "_fold_cnt"}, fold_cnt, exp_fold);
`else
        chk({tag, "_fold_cnt_tied"}, fold_cnt, 8'h00);
`endif
        held = bus.out_data_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_data"}, bus.out_data_o, held);
            chk({tag, "_stall_valid"}, bus.out_valid_o, 1'b1);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        chk({tag, "_valid_drop"}, bus.out_valid_o, 1'b0);
        chk({tag, "_ready_back"}, bus.in_ready_o, 1'b1);
    endtask

    initial begin
        logic [255:0] acc;
        logic [63:0]  p;
        logic [2:0]   s;
        int           nb, seen;

        bus.in_valid_i   = 1'b0;
        bus.in_product_i = '0;
        bus.in_shift_i   = '0;
        bus.in_last_i    = 1'b0;
        bus.out_ready_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_out_data", bus.out_data_o, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_fold_cnt", fold_cnt, 8'h00);
        chk("rst_in_ready", bus.in_ready_o, 1'b1);
        chk("rst_state", dbg_state, 2'd0);

        // single unit product: no folds
        send_beat(64'h1, 3'd0, 1'b1);
        finish_op("one", 32'h1, 7, 0, 0);

        // x^32 reduces to the low polynomial terms with one fold
        send_beat(64'h1_0000_0000, 3'd0, 1'b1);
        finish_op("x32", 32'h0002_C001, 8, 1, 2);

        // equal products cancel
        send_beat(64'hA, 3'd0, 1'b0);
        send_beat(64'hA, 3'd0, 1'b1);
        finish_op("cancel", 32'h0, 7, 0, 1);

        // illegal shift: error pulse, accumulator untouched
        send_beat(64'h5, 3'd7, 1'b0);
        chk("err_pulse", err, 1'b1);
        @(posedge clk); #1;
        chk("err_clear", err, 1'b0);
        send_beat(64'h1, 3'd0, 1'b1);
        finish_op("after_err", 32'h1, 7, 0, 0);

        // reset in the middle of folding
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 3'd6, 1'b1);
        @(posedge clk); #1;
        chk("mid_fold_state", dbg_state, 2'd1);
        rst = 1'b1;
        #1;
        chk("rst_fold_state", dbg_state, 2'd0);
        chk("rst_fold_valid", bus.out_valid_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(64'h3, 3'd0, 1'b1);
        finish_op("post_rst", 32'h3, 7, 0, 0);

        // flush coincident with an accepted last beat
        bus.in_valid_i   = 1'b1;
        bus.in_product_i = 64'hF;
        bus.in_shift_i   = 3'd0;
        bus.in_last_i    = 1'b1;
        flush            = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        flush          = 1'b0;
        chk("flush_state", dbg_state, 2'd0);
        chk("flush_ready", bus.in_ready_o, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid_o) seen++;
        end
        chk("flush_no_output", seen, 0);
        send_beat(64'h7, 3'd0, 1'b1);
        finish_op("post_flush", 32'h7, 7, 0, 0);

        // randomised operations against the bit-serial model
        for (int op = 0; op < 8; op++) begin
            acc = '0;
            nb  = $urandom_range(1, 7);
            for (int b = 0; b < nb; b++) begin
                p   = {$urandom(), $urandom()};
                s   = 3'($urandom_range(0, 6));
                acc = acc ^ (256'(p) << (int'(s) * 32));
                send_beat(p, s, (b == nb - 1));
            end
            finish_op("rand", model_mod(acc), -1, -1, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aespim_reduce_accum.md
Name: aespim_reduce_accum

Overview:
- Parametrised, sequential successor to the combinational clmul product reducer in the AES/PIM datapath.
- Accepts a stream of 2W-bit carry-less products, each with a limb shift index, and XOR-accumulates them into a wide limb buffer.
- On the last beat it folds the buffer iteratively modulo x^W + POLY_LOW and returns one W-bit residue over a valid/ready handshake.
- Sits between the clmul array and the AES/GHASH-style consumer.

Parameters:
- W, 32, limb/field width in bits.
- POLY_LOW, 32'h0002_C001, low terms of the reduction polynomial (x^32+x^17+x^15+x^14+1); W bits wide, must have degree < W-1.
- MAX_SHIFT, 6, largest legal shift_idx; shift k places the product at bit k*W.
- NLIMB, MAX_SHIFT+2, accumulator limbs (derived; not overridable).
- SHIFT_W, $clog2(MAX_SHIFT+1), width of the shift index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  synchronous clear: accumulator zeroed, state forced to ACCUM.
- in_valid_i  in  1  product beat valid.
- in_ready_o  out  1  high only in ACCUM.
- in_product_i  in  2*W  carry-less product.
- in_shift_i  in  SHIFT_W  limb shift index.
- in_last_i  in  1  final beat of the operation.
- out_valid_o  out  1  residue valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  W  reduced residue.
- err_o  out  1  one-cycle pulse: accepted beat had in_shift_i > MAX_SHIFT.
- fold_cnt_o  out  8  fold statistics (see Optional Feature).

Behaviour:
- Reset: state ACCUM, all limbs 0, top=0, out_valid_o=0, out_data_o=0, err_o=0, fold_cnt_o=0, in_ready_o=1 once reset is released.
- States: ACCUM, FOLD, OUT.
- ACCUM:
  - A beat is accepted on in_valid_i && in_ready_o.
  - limb[k] ^= product[W-1:0] and limb[k+1] ^= product[2W-1:W], where k=in_shift_i.
  - If in_shift_i > MAX_SHIFT: the beat is consumed, the accumulator is unchanged, and err_o pulses the next cycle.
  - If in_last_i: the update still applies, then top=NLIMB-1 and next state is FOLD.
- FOLD, one action per cycle, with top the current top limb index:
  - limb[top]!=0: fold step. t = clmul(limb[top], POLY_LOW), 2W-1 bits; limb[top-1] ^= t[W-1:0]; limb[top] = t[2W-2:W]. top is unchanged.
  - limb[top]==0 && top>1: top decrements.
  - limb[top]==0 && top==1: out_data_o=limb[0], out_valid_o=1, next state OUT.
  - Termination is guaranteed by the degree constraint on POLY_LOW. For default parameters, the fold count per limb is at most 3.
- OUT:
  - out_data_o is held stable while out_valid_o && !out_ready_i.
  - On the handshake: out_valid_o=0, all limbs cleared, next state ACCUM.
  - in_ready_o goes high the cycle after the handshake; there is no same-cycle bypass.
- Latency with default parameters (NLIMB=8) and no folds: out_valid_o rises 7 edges after the accepting edge of the last beat. Each fold step adds 1.
- flush_i takes priority over any handshake in the same cycle. It also clears out_valid_o.
- rst_i asserted mid-FOLD or mid-OUT returns immediately to reset values; the partial result is discarded.
- A single-beat operation (in_last_i on the first beat) is legal.
- An empty operation does not exist: there is no output without a last beat.

Optional Feature:
- Macro AESPIM_REDUCE_FOLDCNT_EN.
- Defined:
  - fold_cnt_o counts fold steps (not decrement steps) of the operation in flight.
  - Cleared when the first beat of an operation is accepted; saturates at 8'hFF.
  - Holds its value until the next operation starts.
- Undefined: fold_cnt_o is tied to 0 and the counter logic is absent.

Test Plan:
- Product 64'h1, shift 0, last → out_data_o=32'h1, out_valid_o 7 edges after accept; fold_cnt_o=0 (macro on).
- Product 64'h1_0000_0000, shift 0, last → out_data_o=32'h0002_C001, latency 8 edges, fold_cnt_o=1.
- Two beats 64'hA shift 0, then 64'hA shift 0 last → out_data_o=0. Then product 64'h5 shift 7 → err_o pulses, output unaffected.
- Random 1-7 beats, random shifts 0..6, out_ready_i randomly held low → out_data_o matches the bit-serial GF(2)[x] mod-p model and stays stable while stalled; in_ready_o=0 outside ACCUM.
- rst_i pulsed during FOLD, then a new op with product 64'h3 shift 0 last → out_data_o=32'h3, no stale limbs.
- flush_i asserted in the same cycle as an accepted last beat → returns to ACCUM, no output.
